// File: rtl/ifid_buffer.sv
// Fetch-to-decode decoupling queue: stores {instr, word PC, PC+8} entries in
// strict FIFO order with valid/ready handshakes on both sides and a flush.
module ifid_buffer #(
   parameter int          DEPTH = 2,
   parameter int          PTRW  = 1,
   parameter logic [31:0] NOP   = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   input  logic [31:0]     in_instr,
   input  logic [29:0]     in_pc,
   input  logic [31:0]     in_pc8,
   output logic            in_ready,
   output logic            out_valid,
   output logic [31:0]     out_instr,
   output logic [29:0]     out_pc,
   output logic [31:0]     out_pc8,
   input  logic            out_ready,
   input  logic            flush,
   output logic [PTRW:0]   count
);

   logic [31:0]   instr_mem_r [DEPTH];
   logic [29:0]   pc_mem_r    [DEPTH];
   logic [31:0]   pc8_mem_r   [DEPTH];
   logic [PTRW-1:0] wr_ptr_r;
   logic [PTRW-1:0] rd_ptr_r;
   logic [PTRW:0]   count_r;
   logic            push_s;
   logic            pop_s;

   // Handshake decode and occupancy flags.
   always_comb begin
      in_ready  = (count_r != (PTRW+1)'(DEPTH));
      out_valid = (count_r != {(PTRW+1){1'b0}});
      push_s    = in_valid & in_ready;
      pop_s     = out_valid & out_ready;
      count     = count_r;
   end

   // Head entry presentation; an empty queue shows a NOP with zeroed PCs.
   always_comb begin
      if (out_valid) begin
         out_instr = instr_mem_r[rd_ptr_r];
         out_pc    = pc_mem_r[rd_ptr_r];
         out_pc8   = pc8_mem_r[rd_ptr_r];
      end else begin
         out_instr = NOP;
         out_pc    = 30'h0000_0000;
         out_pc8   = 32'h0000_0000;
      end
   end

   // Pointer and occupancy update; flush wins over any same-cycle push/pop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_r <= {PTRW{1'b0}};
         rd_ptr_r <= {PTRW{1'b0}};
         count_r  <= {(PTRW+1){1'b0}};
      end else if (flush) begin
         wr_ptr_r <= {PTRW{1'b0}};
         rd_ptr_r <= {PTRW{1'b0}};
         count_r  <= {(PTRW+1){1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTRW'(1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTRW'(1);
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + (PTRW+1)'(1);
            2'b01:   count_r <= count_r - (PTRW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage needs no reset: slots are only read while counted valid.
   always_ff @(posedge clk) begin
      if (push_s && !flush) begin
         instr_mem_r[wr_ptr_r] <= in_instr;
         pc_mem_r[wr_ptr_r]    <= in_pc;
         pc8_mem_r[wr_ptr_r]   <= in_pc8;
      end
   end

endmodule

// File: tb/tb_ifid_buffer.sv
// Scoreboard bench for ifid_buffer: directed pushes queue expected entries,
// a negedge monitor pops and compares whenever decode consumes the head.
module tb_ifid_buffer;

   typedef struct packed {
      logic [31:0] instr;
      logic [29:0] pc;
      logic [31:0] pc8;
   } entry_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [31:0] in_instr;
   logic [29:0] in_pc;
   logic [31:0] in_pc8;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [29:0] out_pc;
   logic [31:0] out_pc8;
   logic        out_ready;
   logic        flush;
   logic [1:0]  count;

   int total = 0;
   int bad   = 0;
   entry_t exp_q[$];

   ifid_buffer dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_pc8(in_pc8),
      .in_ready(in_ready),
      .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_pc8(out_pc8),
      .out_ready(out_ready), .flush(flush), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present an entry to fetch side; queue it as expected only if it should be taken.
   task automatic drive(input logic [29:0] pc, input bit expect_take);
      entry_t e;
      e.instr = 32'h1000_0000 | {2'b00, pc};
      e.pc    = pc;
      e.pc8   = {pc, 2'b00} + 32'd8;
      in_valid = 1'b1;
      in_instr = e.instr;
      in_pc    = e.pc;
      in_pc8   = e.pc8;
      if (expect_take) exp_q.push_back(e);
   endtask

   // Monitor: a consumed head must match the oldest expected entry.
   initial begin
      entry_t e;
      forever begin
         @(negedge clk);
         if (reset && out_valid && out_ready && !flush) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_pop_pc", {2'b00, out_pc}, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               chk("pop_instr", out_instr, e.instr);
               chk("pop_pc", {2'b00, out_pc}, {2'b00, e.pc});
               chk("pop_pc8", out_pc8, e.pc8);
            end
         end
      end
   end

   initial begin
      reset = 1'b0; in_valid = 1'b1; in_instr = 32'hDEAD_BEEF; in_pc = 30'h3FF;
      in_pc8 = 32'h1234; out_ready = 1'b0; flush = 1'b0;

      // 1. reset with in_valid high
      step(); step();
      chk("rst_count", {30'd0, count}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_instr", out_instr, 32'h0000_0000);
      chk("rst_out_pc", {2'b00, out_pc}, 32'd0);
      chk("rst_out_pc8", out_pc8, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
      reset = 1'b1;
      step();
      chk("post_rst_count", {30'd0, count}, 32'd0);

      // 2. single pass
      in_valid = 1'b1; in_instr = 32'h2108_0004; in_pc = 30'h10; in_pc8 = 32'h48;
      exp_q.push_back('{instr: 32'h2108_0004, pc: 30'h10, pc8: 32'h48});
      step();
      in_valid = 1'b0;
      chk("single_out_valid", {31'd0, out_valid}, 32'd1);
      chk("single_out_pc", {2'b00, out_pc}, 32'h10);
      chk("single_out_pc8", out_pc8, 32'h48);
      chk("single_count", {30'd0, count}, 32'd1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("single_drain_count", {30'd0, count}, 32'd0);

      // 3. fill and back-pressure
      for (int i = 0; i < 3; i++) begin
         drive(30'(i), i < 2);
         step();
      end
      in_valid = 1'b0;
      chk("full_count", {30'd0, count}, 32'd2);
      chk("full_in_ready", {31'd0, in_ready}, 32'd0);
      chk("full_head_pc", {2'b00, out_pc}, 32'd0);
      out_ready = 1'b1;
      step(); step();
      out_ready = 1'b0;
      chk("drain_count", {30'd0, count}, 32'd0);
      chk("drain_out_valid", {31'd0, out_valid}, 32'd0);

      // 4. streaming through the wrap
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive(30'(i), 1'b1);
         step();
         chk("stream_count", {30'd0, count}, 32'd1);
      end
      in_valid = 1'b0;
      step();
      out_ready = 1'b0;
      chk("stream_end_count", {30'd0, count}, 32'd0);

      // 5. flush while full with a wrong-path push
      drive(30'h30, 1'b1); step();
      drive(30'h31, 1'b1); step();
      chk("pre_flush_count", {30'd0, count}, 32'd2);
      drive(30'h20, 1'b0);
      flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      exp_q.delete();
      chk("flush_count", {30'd0, count}, 32'd0);
      chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
      drive(30'h40, 1'b1); step();
      in_valid = 1'b0;
      chk("post_flush_head", {2'b00, out_pc}, 32'h40);
      // flush with push and pop both offered at count=1
      drive(30'h41, 1'b0);
      out_ready = 1'b1; flush = 1'b1;
      exp_q.delete();
      step();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      chk("flush_pp_count", {30'd0, count}, 32'd0);

      // 6. asynchronous reset between edges
      drive(30'h50, 1'b1); step();
      drive(30'h51, 1'b1); step();
      in_valid = 1'b0;
      chk("pre_arst_count", {30'd0, count}, 32'd2);
      #2 reset = 1'b0;
      #1;
      exp_q.delete();
      chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_count", {30'd0, count}, 32'd0);
      chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("arst_out_instr", out_instr, 32'h0000_0000);
      #1 reset = 1'b1;
      step();
      drive(30'h60, 1'b1); step();
      in_valid = 1'b0;
      chk("post_arst_head", {2'b00, out_pc}, 32'h60);
      chk("post_arst_count", {30'd0, count}, 32'd1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      step();
      chk("leftover_expected", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
